// File: rtl/alu_arb_pkg.sv
// Shared types for the two-requester ALU arbiter: opcodes, slot state and select decode.
package alu_arb_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_SLT = 3'd4
   } alu_op_e;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   localparam logic [2:0] OP_LAST_LEGAL = 3'd4;

   typedef struct packed {
      logic add;
      logic sub;
      logic and_op;
      logic or_op;
      logic slt;
   } alu_sel_t;

   // Illegal opcodes fall through with every select line low.
   function automatic alu_sel_t decode_op(input logic [2:0] op);
      alu_sel_t sel;
      sel = '0;
      case (op)
         OP_ADD:  sel.add    = 1'b1;
         OP_SUB:  sel.sub    = 1'b1;
         OP_AND:  sel.and_op = 1'b1;
         OP_OR:   sel.or_op  = 1'b1;
         OP_SLT:  sel.slt    = 1'b1;
         default: sel        = '0;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and the response consumer.
interface alu_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             req0_valid;
   logic             req0_ready;
   logic [2:0]       req0_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;

   logic             req1_valid;
   logic             req1_ready;
   logic [2:0]       req1_op;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;

   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_zero;
   logic             rsp_err;

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
   );

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
   );
endinterface

// File: rtl/alu.sv
// Combinational ALU driven by one-hot select lines; no select asserted yields zero.
module alu #(
   parameter int WIDTH = 32
) (
   input  logic             sel_add,
   input  logic             sel_sub,
   input  logic             sel_and,
   input  logic             sel_or,
   input  logic             sel_slt,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result
);
   always_comb begin
      result = '0;
      if (sel_add) result = a + b;
      if (sel_sub) result = a - b;
      if (sel_and) result = a & b;
      if (sel_or)  result = a | b;
      if (sel_slt) result = {{(WIDTH-1){1'b0}}, (a < b)};
   end
endmodule

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on contention the side that did not win last time is chosen.
module rr_pick2 (
   input  logic       en,
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant_vec,
   output logic       grant_id
);
   always_comb begin
      grant_vec = 2'b00;
      grant_id  = 1'b0;
      if (en) begin
         if (valid == 2'b11) grant_id = ~last_grant;
         else                grant_id = valid[1];
         if (valid != 2'b00) grant_vec = grant_id ? 2'b10 : 2'b01;
      end
   end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters; the granted op is computed and captured in a
// single registered response slot that can drain and refill on the same edge.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          rst_n,
   alu_arbiter_if.slave bus
);
   state_e           state;
   state_e           state_nxt;
   logic             last_grant;
   logic             can_accept;
   logic             accept;
   logic [1:0]       grant_vec;
   logic             grant_id;
   logic [2:0]       op_sel;
   logic [WIDTH-1:0] a_sel;
   logic [WIDTH-1:0] b_sel;
   logic [WIDTH-1:0] alu_result;
   alu_sel_t         sel;
   logic             legal;

   logic [WIDTH-1:0] result_p1;
   logic             zero_p1;
   logic             err_p1;
   logic             id_p1;

   rr_pick2 u_pick (
      .en         (can_accept),
      .valid      ({bus.req1_valid, bus.req0_valid}),
      .last_grant (last_grant),
      .grant_vec  (grant_vec),
      .grant_id   (grant_id)
   );

   assign accept = |grant_vec;

   assign op_sel = grant_id ? bus.req1_op : bus.req0_op;
   assign a_sel  = grant_id ? bus.req1_a  : bus.req0_a;
   assign b_sel  = grant_id ? bus.req1_b  : bus.req0_b;
   assign sel    = decode_op(op_sel);
   assign legal  = (op_sel <= OP_LAST_LEGAL);

   alu #(.WIDTH(WIDTH)) u_alu (
      .sel_add (sel.add),
      .sel_sub (sel.sub),
      .sel_and (sel.and_op),
      .sel_or  (sel.or_op),
      .sel_slt (sel.slt),
      .a       (a_sel),
      .b       (b_sel),
      .result  (alu_result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (accept) state_nxt = FULL;
         FULL:    if (accept) state_nxt = FULL;
                  else if (bus.rsp_ready) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   // Ready is gated by rst_n so no requester sees a grant while reset is held.
   always_comb begin
      can_accept = rst_n && ((state == EMPTY) || bus.rsp_ready);
   end

   // ---- response slot (stage p1) ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_p1  <= '0;
         zero_p1    <= 1'b0;
         err_p1     <= 1'b0;
         id_p1      <= 1'b0;
         last_grant <= 1'b1;
      end else if (accept) begin
         result_p1  <= legal ? alu_result : '0;
         zero_p1    <= legal ? (alu_result == '0) : 1'b1;
         err_p1     <= ~legal;
         id_p1      <= grant_id;
         last_grant <= grant_id;
      end
   end

   assign bus.req0_ready = grant_vec[0];
   assign bus.req1_ready = grant_vec[1];
   assign bus.rsp_valid  = (state == FULL);
   assign bus.rsp_id     = id_p1;
   assign bus.rsp_result = result_p1;
   assign bus.rsp_zero   = zero_p1;
   assign bus.rsp_err    = err_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: handshake, round-robin, backpressure, arithmetic edges, reset.
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   alu_arbiter_if #(.WIDTH(32)) bus ();

   alu_arbiter #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int r, input logic v, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      if (r == 0) begin
         bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
      end else begin
         bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
      end
   endtask

   task automatic chk_rsp(input string tag, input logic v, input logic id,
                          input logic [31:0] res, input logic z, input logic e);
      chk({tag, "_valid"},  32'(bus.rsp_valid), 32'(v));
      chk({tag, "_id"},     32'(bus.rsp_id),    32'(id));
      chk({tag, "_result"}, bus.rsp_result,     res);
      chk({tag, "_zero"},   32'(bus.rsp_zero),  32'(z));
      chk({tag, "_err"},    32'(bus.rsp_err),   32'(e));
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
   } vec_t;

   vec_t vecs [6];

   initial begin
      n_cmp = 0;
      n_err = 0;
      vecs[0] = '{OP_ADD, 32'hFFFF_FFFF, 32'h1,      32'h0,         1'b1};
      vecs[1] = '{OP_SLT, 32'hFFFF_FFFF, 32'h1,      32'h0,         1'b1};
      vecs[2] = '{OP_SLT, 32'h1,         32'h2,      32'h1,         1'b0};
      vecs[3] = '{OP_AND, 32'hF0F0,      32'h0FF0,   32'h00F0,      1'b0};
      vecs[4] = '{OP_OR,  32'hF0F0,      32'h0FF0,   32'hFFF0,      1'b0};
      vecs[5] = '{OP_SUB, 32'h0,         32'h1,      32'hFFFF_FFFF, 1'b0};

      // Reset with a request pending: nothing may be granted.
      rst_n = 1'b0;
      bus.rsp_ready = 1'b0;
      drive(0, 1'b1, OP_ADD, 32'd1, 32'd1);
      drive(1, 1'b0, OP_ADD, 32'd0, 32'd0);
      repeat (2) step();
      chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
      chk_rsp("rst", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      drive(0, 1'b0, OP_ADD, 32'd0, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Single op from requester 0.
      drive(0, 1'b1, OP_ADD, 32'd5, 32'd7);
      #1;
      chk("single_ready0", 32'(bus.req0_ready), 32'd1);
      chk("single_ready1", 32'(bus.req1_ready), 32'd0);
      step();
      drive(0, 1'b0, OP_ADD, 32'd0, 32'd0);
      chk_rsp("single", 1'b1, 1'b0, 32'd12, 1'b0, 1'b0);
      bus.rsp_ready = 1'b1;
      step();
      chk("single_drain", 32'(bus.rsp_valid), 32'd0);

      // One op from requester 1 so that requester 0 wins the next contention.
      drive(1, 1'b1, OP_ADD, 32'd1, 32'd1);
      step();
      drive(1, 1'b0, OP_ADD, 32'd0, 32'd0);
      chk_rsp("r1", 1'b1, 1'b1, 32'd2, 1'b0, 1'b0);
      step();

      // Continuous contention with rsp_ready high: grants alternate 0,1,0,1.
      drive(0, 1'b1, OP_ADD, 32'd10, 32'd20);
      drive(1, 1'b1, OP_SUB, 32'd100, 32'd1);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("cont%0d_ready0", k), 32'(bus.req0_ready), 32'(k % 2 == 0));
         chk($sformatf("cont%0d_ready1", k), 32'(bus.req1_ready), 32'(k % 2 == 1));
         step();
         chk_rsp($sformatf("cont%0d", k), 1'b1, 1'(k % 2),
                 (k % 2 == 0) ? 32'd30 : 32'd99, 1'b0, 1'b0);
      end
      drive(0, 1'b0, OP_ADD, 32'd0, 32'd0);
      drive(1, 1'b0, OP_ADD, 32'd0, 32'd0);
      step();
      chk("cont_drain", 32'(bus.rsp_valid), 32'd0);

      // Backpressure: slot held FULL with SUB 3-3 while requester 1 waits.
      bus.rsp_ready = 1'b0;
      drive(0, 1'b1, OP_SUB, 32'd3, 32'd3);
      #1;
      chk("bp_ready0", 32'(bus.req0_ready), 32'd1);
      step();
      drive(0, 1'b0, OP_ADD, 32'd0, 32'd0);
      drive(1, 1'b1, OP_ADD, 32'd4, 32'd5);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("bp%0d_ready1", k), 32'(bus.req1_ready), 32'd0);
         chk_rsp($sformatf("bp%0d", k), 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
         step();
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready1", 32'(bus.req1_ready), 32'd1);
      step();
      drive(1, 1'b0, OP_ADD, 32'd0, 32'd0);
      chk_rsp("bp_refill", 1'b1, 1'b1, 32'd9, 1'b0, 1'b0);
      step();
      chk("bp_drain", 32'(bus.rsp_valid), 32'd0);

      // Arithmetic edges, issued back to back at one per cycle.
      for (int k = 0; k < 6; k++) begin
         drive(0, 1'b1, vecs[k].op, vecs[k].a, vecs[k].b);
         #1;
         chk($sformatf("arith%0d_ready0", k), 32'(bus.req0_ready), 32'd1);
         step();
         chk_rsp($sformatf("arith%0d", k), 1'b1, 1'b0, vecs[k].res, vecs[k].z, 1'b0);
      end
      drive(0, 1'b0, OP_ADD, 32'd0, 32'd0);
      step();

      // Illegal opcode from requester 1.
      drive(1, 1'b1, 3'd6, 32'd123, 32'd456);
      #1;
      chk("ill_ready1", 32'(bus.req1_ready), 32'd1);
      step();
      drive(1, 1'b0, OP_ADD, 32'd0, 32'd0);
      chk_rsp("ill", 1'b1, 1'b1, 32'd0, 1'b1, 1'b1);
      step();

      // Asynchronous reset while FULL; requester 0 last won, reset must restore last_grant=1.
      bus.rsp_ready = 1'b0;
      drive(0, 1'b1, OP_ADD, 32'd1, 32'd1);
      step();
      drive(0, 1'b0, OP_ADD, 32'd0, 32'd0);
      chk("mid_full", 32'(bus.rsp_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_rsp("mid_rst", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      drive(0, 1'b1, OP_ADD, 32'd2, 32'd3);
      drive(1, 1'b1, OP_ADD, 32'd6, 32'd7);
      bus.rsp_ready = 1'b1;
      #1;
      chk("mid_rst_ready0", 32'(bus.req0_ready), 32'd0);
      chk("mid_rst_ready1", 32'(bus.req1_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready0", 32'(bus.req0_ready), 32'd1);
      chk("post_rst_ready1", 32'(bus.req1_ready), 32'd0);
      step();
      chk_rsp("post_rst", 1'b1, 1'b0, 32'd5, 1'b0, 1'b0);
      drive(0, 1'b0, OP_ADD, 32'd0, 32'd0);
      drive(1, 1'b0, OP_ADD, 32'd0, 32'd0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `alu` between two requesters, e.g. the execute stage and the address-generation/branch unit. Uses round-robin arbitration with valid/ready handshakes. Each accepted request is decoded into the ALU's one-hot select lines. The result, zero flag and requester ID are captured in a single registered response slot, which supports back-to-back throughput of one operation per cycle.

## Interface
Parameters:
- WIDTH, 32, operand/result width passed to the ALU.

Ports:
- clk  in  1  rising-edge clock; one clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  3  alu_op_e opcode.
- req0_a, req0_b  in  WIDTH  operands.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  out  1  response slot full.
- rsp_ready  in  1  consumer takes the response this cycle.
- rsp_id  out  1  requester that issued the response.
- rsp_result  out  WIDTH  ALU result.
- rsp_zero  out  1  rsp_result == 0.
- rsp_err  out  1  opcode was illegal.

## Operation
- alu_op_e encoding:
  - ADD=0, SUB=1, AND=2, OR=3, SLT=4.
  - 5–7 are illegal.
- Decode drives exactly one ALU select line per legal opcode.
- SLT is an unsigned compare; result is zero-extended 0 or 1.
- ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
- Illegal opcode handling:
  - The request is still accepted.
  - rsp_result=0, rsp_zero=1, rsp_err=1.
  - No ALU select line is asserted.
- FSM states:
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1).
- can_accept = EMPTY, or (FULL and rsp_ready).
- Arbitration when can_accept:
  - One requester valid: that requester is granted.
  - Both valid: grant the requester not equal to last_grant.
  - Exactly one reqN_ready is high, on the granted requester only.
  - reqN_ready may depend combinationally on reqN_valid and rsp_ready.
- On accept:
  - Response slot loads result, zero, err and id of the granted requester.
  - last_grant ← granted id.
  - State → FULL.
- FULL, rsp_ready=1, no valid request: state → EMPTY.
- FULL, rsp_ready=0:
  - Slot contents are held stable.
  - Both reqN_ready are low.
- Requester rule: while reqN_valid=1 and reqN_ready=0, the requester holds op, a and b stable and keeps valid high.
- The arbiter does not check the requester rule.

## Timing
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0.
  - last_grant=1, so requester 0 wins the first contention.
  - State EMPTY.
- Reset is asynchronous and active-low: rsp_valid drops immediately on rst_n fall.
  - An in-flight response is discarded.
  - reqN_ready is low while rst_n=0.
- Latency: accepted in cycle N → rsp_valid and payload visible in cycle N+1.
- Throughput: with rsp_ready held high, one accept every cycle.
- Under continuous contention, grants alternate 0,1,0,1.
- Simultaneous drain and accept in the same edge:
  - Old response is consumed.
  - New response is loaded.
  - rsp_valid stays 1.
- No combinational path from req*_a/b to rsp_* outputs; all rsp_* are registered.

## Structure
- Package alu_arb_pkg:
  - alu_op_e typedef (3-bit) with the encodings above.
  - State enum {EMPTY, FULL}.
  - OP_LAST_LEGAL = 4.
- Sub-module rr_pick2, purely combinational.
  - Inputs: valid[1:0], last_grant, en.
  - Outputs: grant_vec[1:0], grant_id.
- Top level contains:
  - Operand mux.
  - Opcode decode to one-hot selects.
  - One instance of the existing `alu`.
  - Response register and FSM.

## Test plan
- Reset then single op:
  - Stimulus: req0 ADD a=5, b=7.
  - Required: req0_ready=1 in cycle 0; cycle 1 rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0.
- Contention:
  - Stimulus: both valid for 4 cycles, rsp_ready=1.
  - Required: grant ids 0,1,0,1; each requester's result matches its own operands.
- Backpressure:
  - Stimulus: response FULL with SUB 3−3, rsp_ready=0 for 3 cycles, req1 valid throughout.
  - Required: rsp_result=0 and rsp_zero=1 held stable; req1_ready=0 throughout.
  - Then rsp_ready=1: req1 accepted the same cycle.
- Arithmetic edges:
  - Stimulus and required results:
    - ADD 0xFFFFFFFF+1 → 0 with zero=1.
    - SLT 0xFFFFFFFF<1 → 0 (unsigned compare).
    - SLT 1<2 → 1.
    - AND 0xF0F0&0x0FF0 → 0x00F0.
    - OR → 0xFFF0.
- Illegal op:
  - Stimulus: req1 op=6.
  - Required: accepted; rsp_err=1, rsp_result=0, rsp_zero=1, rsp_id=1.
- Reset mid-operation:
  - Stimulus: rst_n low asynchronously while FULL.
  - Required: rsp_valid=0 before the next clock edge.
  - After release with both requesters valid: requester 0 granted first.
